// File: rtl/arp_note_sequencer_pkg.sv
// ============================================================================
// Module      : arp_pkg
// Description : Shared types, widths and chord-step helper for the arpeggiator
//               note sequencer. Optional feature macro: ARP_OCTAVE_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package arp_pkg;

    localparam int DIV_W       = 12;
    localparam int PROD_W      = 15;
    localparam int RATIO_THIRD = 13;
    localparam int RATIO_FIFTH = 11;

    typedef enum logic [1:0] {
        ROOT   = 2'd0,
        THIRD  = 2'd1,
        FIFTH  = 2'd2,
        OCTAVE = 2'd3
    } note_t;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        ARP  = 1'b1
    } state_t;

    // Chord degree that follows n; the octave step exists only in the 4-note build.
    function automatic note_t next_note(input note_t n);
        note_t r;
        case (n)
            ROOT:    r = THIRD;
            THIRD:   r = FIFTH;
`ifdef ARP_OCTAVE_EN
            FIFTH:   r = OCTAVE;
`endif
            default: r = ROOT;
        endcase
        return r;
    endfunction

endpackage

`default_nettype wire

// File: rtl/arp_note_sequencer_if.sv
// ============================================================================
// Module      : arp_note_sequencer_if
// Description : Switch/button inputs and BRAM-address / note outputs of the
//               note sequencer, grouped with master (sequencer) and slave views.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface arp_note_sequencer_if;
    import arp_pkg::*;

    logic [7:0] SW;
    logic       arp_btn;
    logic [7:0] addra;
    logic       sample_stb;
    note_t      note;
    logic       arp_en;

    modport master (
        input  SW,
        input  arp_btn,
        output addra,
        output sample_stb,
        output note,
        output arp_en
    );

    modport slave (
        output SW,
        output arp_btn,
        input  addra,
        input  sample_stb,
        input  note,
        input  arp_en
    );

endinterface

`default_nettype wire

// File: rtl/arp_note_sequencer_tone_div.sv
// ============================================================================
// Module      : arp_tone_div
// Description : Tone divider; counts 0..P-1 and pulses o_wrap on the last
//               count. The period is latched only at a wrap.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module arp_tone_div
    import arp_pkg::*;
(
    input  wire logic             clk,
    input  wire logic             rst_n,
    input  wire logic [DIV_W-1:0] i_period,
    output logic                  o_wrap
);

    logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
    logic [DIV_W-1:0] pcur_q, pcur_d;
    logic             loaded_q, loaded_d;
    logic [DIV_W-1:0] w_pcur;
    logic             w_wrap;

    // Until the first latch after reset the live input period is in force.
    always_comb begin
        w_pcur    = loaded_q ? pcur_q : i_period;
        w_wrap    = (div_cnt_q == (w_pcur - DIV_W'(1)));
        div_cnt_d = w_wrap ? '0 : div_cnt_q + DIV_W'(1);
        pcur_d    = (w_wrap || !loaded_q) ? i_period : pcur_q;
        loaded_d  = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt_q <= '0;
            pcur_q    <= '0;
            loaded_q  <= 1'b0;
        end else begin
            div_cnt_q <= div_cnt_d;
            pcur_q    <= pcur_d;
            loaded_q  <= loaded_d;
        end
    end

    assign o_wrap = w_wrap;

endmodule

`default_nettype wire

// File: rtl/arp_note_sequencer.sv
// ============================================================================
// Module      : arp_note_sequencer
// Description : BRAM read-address generator and arpeggio note FSM. Optional
//               feature macro: ARP_OCTAVE_EN (4-note pattern with octave).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module arp_note_sequencer
    import arp_pkg::*;
#(
    parameter int BASE_DIV  = 1493,
    parameter int NOTE_HOLD = 25_000_000
) (
    input  wire logic            CLK100MHZ,
    input  wire logic            CPU_RESETN,
    arp_note_sequencer_if.master bus
);

    localparam int                C_HOLD_W    = (NOTE_HOLD > 1) ? $clog2(NOTE_HOLD) : 1;
    localparam logic [C_HOLD_W-1:0] C_HOLD_LAST = C_HOLD_W'(NOTE_HOLD - 1);

    logic [DIV_W-1:0]  w_p0, w_p_third, w_p_fifth, w_p_sel;
    logic [PROD_W-1:0] w_prod_third, w_prod_fifth;
    logic              w_wrap, w_toggle;

    state_t              state_q, state_d;
    note_t               note_q, note_d;
    logic [C_HOLD_W-1:0] hold_q, hold_d;
    logic [7:0]          addra_q, addra_d;
    logic                stb_q, stb_d;
    logic                btn_q, btn_d, btn_prev_q, btn_prev_d;

    // Ratios are x/16: widen to the product width, then truncate the shift.
    always_comb begin
        w_p0         = DIV_W'(BASE_DIV) + {2'b00, bus.SW, 2'b00};
        w_prod_third = PROD_W'(w_p0) * PROD_W'(RATIO_THIRD);
        w_prod_fifth = PROD_W'(w_p0) * PROD_W'(RATIO_FIFTH);
        w_p_third    = DIV_W'(w_prod_third >> 4);
        w_p_fifth    = DIV_W'(w_prod_fifth >> 4);
    end

`ifdef ARP_OCTAVE_EN
    logic [DIV_W-1:0] w_p_oct;
    assign w_p_oct = w_p0 >> 1;
`endif

    always_comb begin
        case (note_q)
            THIRD:   w_p_sel = w_p_third;
            FIFTH:   w_p_sel = w_p_fifth;
`ifdef ARP_OCTAVE_EN
            OCTAVE:  w_p_sel = w_p_oct;
`endif
            default: w_p_sel = w_p0;
        endcase
    end

    arp_tone_div u_tone_div (
        .clk      (CLK100MHZ),
        .rst_n    (CPU_RESETN),
        .i_period (w_p_sel),
        .o_wrap   (w_wrap)
    );

    // A toggle outranks a hold terminal, so the note never advances on it.
    always_comb begin
        btn_d      = bus.arp_btn;
        btn_prev_d = btn_q;
        w_toggle   = btn_q & ~btn_prev_q;
        addra_d    = addra_q + {7'd0, w_wrap};
        stb_d      = w_wrap;
        state_d    = state_q;
        note_d     = note_q;
        hold_d     = hold_q;
        case (state_q)
            IDLE: begin
                note_d = ROOT;
                hold_d = '0;
                if (w_toggle) state_d = ARP;
            end
            ARP: begin
                if (w_toggle) begin
                    state_d = IDLE;
                    note_d  = ROOT;
                    hold_d  = '0;
                end else if (hold_q == C_HOLD_LAST) begin
                    hold_d = '0;
                    note_d = next_note(note_q);
                end else begin
                    hold_d = hold_q + C_HOLD_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
        if (!CPU_RESETN) begin
            state_q    <= IDLE;
            note_q     <= ROOT;
            hold_q     <= '0;
            addra_q    <= '0;
            stb_q      <= 1'b0;
            btn_q      <= 1'b0;
            btn_prev_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            note_q     <= note_d;
            hold_q     <= hold_d;
            addra_q    <= addra_d;
            stb_q      <= stb_d;
            btn_q      <= btn_d;
            btn_prev_q <= btn_prev_d;
        end
    end

    assign bus.addra      = addra_q;
    assign bus.sample_stb = stb_q;
    assign bus.note       = note_q;
    assign bus.arp_en     = (state_q == ARP);

endmodule

`default_nettype wire
